// File: rtl/gal_olmc_cfg_seq.sv
// GAL OLMC configuration sequencer: collects per-OLMC writes in a shadow, then
// shifts the full frame out serially and latches it into the active config.
//
// state | meaning
// IDLE  | accepting writes; a commit (or pending commit) starts a frame
// SHIFT | frame bits go out on sdo/sclk, MSB first
// LATCH | one-cycle sload strobe; active config updates at its end
module gal_olmc_cfg_seq #(
    parameter int N_OLMC = 8,
    parameter int DIV    = 2,
    localparam int IW    = (N_OLMC > 1) ? $clog2(N_OLMC) : 1
) (
    input  logic              C,
    input  logic              R,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IW-1:0]     req_idx,
    input  logic              req_reg,
    input  logic              req_inv,
    input  logic              req_oe,
    input  logic              commit,
    output logic              busy,
    output logic              err,
    output logic              sclk,
    output logic              sdo,
    output logic              sload,
    output logic              done,
    output logic [N_OLMC-1:0] cfg_reg,
    output logic [N_OLMC-1:0] cfg_inv,
    output logic [N_OLMC-1:0] cfg_oe
);
    localparam int FW = 3 * N_OLMC;
    localparam int BW = $clog2(FW + 1);
    localparam int DW = $clog2(DIV + 1);
    localparam logic [31:0] N_U = N_OLMC;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
    state_t state, state_nxt;

    logic [N_OLMC-1:0] sh_reg, sh_inv, sh_oe;
    logic [N_OLMC-1:0] sh_reg_nxt, sh_inv_nxt, sh_oe_nxt;
    logic [N_OLMC-1:0] snap_reg, snap_inv, snap_oe;
    logic [FW-1:0]     frame, frame_nxt;
    logic [DW-1:0]     div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              phase_hi;
    logic              pend;
    logic              wr_acc, idx_ok, start, div_end, bit_end, last_bit;

    assign wr_acc   = req_valid & req_ready;
    assign idx_ok   = (32'(req_idx) < N_U);
    assign start    = (state == IDLE) && (commit || pend);
    assign div_end  = (div_cnt == DW'(DIV - 1));
    assign bit_end  = phase_hi && div_end;
    assign last_bit = (bit_cnt == BW'(FW - 1));

    // Shadow including a write accepted this cycle, so a same-cycle commit sees it.
    always_comb begin
        sh_reg_nxt = sh_reg;
        sh_inv_nxt = sh_inv;
        sh_oe_nxt  = sh_oe;
        if (wr_acc && idx_ok) begin
            sh_reg_nxt[req_idx] = req_reg;
            sh_inv_nxt[req_idx] = req_inv;
            sh_oe_nxt[req_idx]  = req_oe;
        end
    end

    always_comb begin
        frame_nxt = '0;
        for (int i = 0; i < N_OLMC; i++) begin
            frame_nxt[3*i+2] = sh_oe_nxt[i];
            frame_nxt[3*i+1] = sh_inv_nxt[i];
            frame_nxt[3*i]   = sh_reg_nxt[i];
        end
    end

    always_ff @(posedge C) begin
        if (R) state <= IDLE;
        else   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b0;
        sclk      = 1'b0;
        sdo       = 1'b0;
        sload     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                sclk = phase_hi;
                sdo  = frame[FW-1];
                if (bit_end && last_bit) state_nxt = LATCH;
            end
            LATCH: begin
                busy      = 1'b1;
                sload     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge C) begin
        if (R) begin
            sh_reg   <= '0;
            sh_inv   <= '0;
            sh_oe    <= '1;
            snap_reg <= '0;
            snap_inv <= '0;
            snap_oe  <= '1;
            cfg_reg  <= '0;
            cfg_inv  <= '0;
            cfg_oe   <= '1;
            frame    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            phase_hi <= 1'b0;
            pend     <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            sh_reg <= sh_reg_nxt;
            sh_inv <= sh_inv_nxt;
            sh_oe  <= sh_oe_nxt;
            err    <= wr_acc && !idx_ok;
            done   <= (state == LATCH);

            if (start)                       pend <= 1'b0;
            else if (state != IDLE && commit) pend <= 1'b1;

            if (start) begin
                snap_reg <= sh_reg_nxt;
                snap_inv <= sh_inv_nxt;
                snap_oe  <= sh_oe_nxt;
                frame    <= frame_nxt;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                phase_hi <= 1'b0;
            end else if (state == SHIFT) begin
                if (div_end) begin
                    div_cnt  <= '0;
                    phase_hi <= ~phase_hi;
                    // Advance to the next bit only after the high phase, so sdo
                    // moves while sclk is low.
                    if (phase_hi) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        frame   <= {frame[FW-2:0], 1'b0};
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end

            if (state == LATCH) begin
                cfg_reg <= snap_reg;
                cfg_inv <= snap_inv;
                cfg_oe  <= snap_oe;
            end
        end
    end
endmodule

// File: tb/tb_gal_olmc_cfg_seq.sv
// Directed bench for gal_olmc_cfg_seq: main instance N_OLMC=8/DIV=2, plus
// N_OLMC=6 for out-of-range index handling and N_OLMC=1/DIV=1 for minimum timing.
module tb_gal_olmc_cfg_seq;
    logic C = 1'b0;
    logic R;
    always #5 C = ~C;

    logic       req_valid, req_reg, req_inv, req_oe, commit;
    logic [2:0] req_idx;
    logic       req_ready, busy, err, sclk, sdo, sload, done;
    logic [7:0] cfg_reg, cfg_inv, cfg_oe;

    logic       v2, reg2, inv2, oe2, commit2;
    logic [2:0] idx2;
    logic       rdy2, busy2, err2, sclk2, sdo2, sload2, done2;
    logic [5:0] cfgr2, cfgi2, cfgo2;

    logic       v3, reg3, inv3, oe3, commit3;
    logic [0:0] idx3;
    logic       rdy3, busy3, err3, sclk3, sdo3, sload3, done3;
    logic [0:0] cfgr3, cfgi3, cfgo3;

    int n_chk = 0;
    int n_err = 0;

    gal_olmc_cfg_seq #(.N_OLMC(8), .DIV(2)) u_dut (
        .C(C), .R(R), .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .req_reg(req_reg), .req_inv(req_inv), .req_oe(req_oe), .commit(commit),
        .busy(busy), .err(err), .sclk(sclk), .sdo(sdo), .sload(sload), .done(done),
        .cfg_reg(cfg_reg), .cfg_inv(cfg_inv), .cfg_oe(cfg_oe));

    gal_olmc_cfg_seq #(.N_OLMC(6), .DIV(2)) u_dut6 (
        .C(C), .R(R), .req_valid(v2), .req_ready(rdy2), .req_idx(idx2),
        .req_reg(reg2), .req_inv(inv2), .req_oe(oe2), .commit(commit2),
        .busy(busy2), .err(err2), .sclk(sclk2), .sdo(sdo2), .sload(sload2), .done(done2),
        .cfg_reg(cfgr2), .cfg_inv(cfgi2), .cfg_oe(cfgo2));

    gal_olmc_cfg_seq #(.N_OLMC(1), .DIV(1)) u_dut1 (
        .C(C), .R(R), .req_valid(v3), .req_ready(rdy3), .req_idx(idx3),
        .req_reg(reg3), .req_inv(inv3), .req_oe(oe3), .commit(commit3),
        .busy(busy3), .err(err3), .sclk(sclk3), .sdo(sdo3), .sload(sload3), .done(done3),
        .cfg_reg(cfgr3), .cfg_inv(cfgi3), .cfg_oe(cfgo3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge C);
        #1;
    endtask

    // Observe the main instance for ncyc cycles starting at cycle t+1 after a commit.
    // At cycle t+inj_k a commit plus a write to idx 5 are injected.
    task automatic run_mon(input int ncyc, input int inj_k,
                           output logic [63:0] bits, output int rises,
                           output int busy_first, output int busy_last,
                           output int sload_k, output int done_k1, output int done_k2,
                           output int done_n, output int stab_err,
                           output logic rdy_inj, output logic [7:0] cfg_mid);
        logic prev_sclk, hold_sdo;
        bits = '0; rises = 0; busy_first = -1; busy_last = -1; sload_k = -1;
        done_k1 = -1; done_k2 = -1; done_n = 0; stab_err = 0; rdy_inj = 1'bx;
        cfg_mid = '0; prev_sclk = 1'b0; hold_sdo = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (sclk && !prev_sclk) begin
                rises++;
                bits = {bits[62:0], sdo};
                hold_sdo = sdo;
            end else if (sclk && (sdo !== hold_sdo)) begin
                stab_err++;
            end
            prev_sclk = sclk;
            if (busy) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (sload && sload_k < 0) sload_k = k;
            if (done) begin
                done_n++;
                if (done_k1 < 0) done_k1 = k;
                else             done_k2 = k;
            end
            if (k == 97) cfg_mid = cfg_reg;
            if (k == inj_k) begin
                rdy_inj   = req_ready;
                commit    = 1'b1;
                req_valid = 1'b1;
                req_idx   = 3'd5;
                req_reg   = 1'b1;
                req_inv   = 1'b1;
                req_oe    = 1'b0;
            end
            tick;
            commit    = 1'b0;
            req_valid = 1'b0;
        end
    endtask

    logic [63:0] bits;
    int rises, bf, bl, slk, dk1, dk2, dn, stab;
    logic rdy_inj;
    logic [7:0] cmid;

    initial begin
        R = 1'b1;
        req_valid = 0; req_idx = 0; req_reg = 0; req_inv = 0; req_oe = 0; commit = 0;
        v2 = 0; idx2 = 0; reg2 = 0; inv2 = 0; oe2 = 0; commit2 = 0;
        v3 = 0; idx3 = 0; reg3 = 0; inv3 = 0; oe3 = 0; commit3 = 0;
        tick; tick;
        R = 1'b0;

        chk("rst_cfg_reg", cfg_reg, 8'h00);
        chk("rst_cfg_inv", cfg_inv, 8'h00);
        chk("rst_cfg_oe", cfg_oe, 8'hFF);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy_sclk_sdo_sload", {busy, sclk, sdo, sload, done, err}, 0);

        // Out-of-range index on the 6-OLMC instance
        v2 = 1; idx2 = 3'd7; reg2 = 1; inv2 = 1; oe2 = 0;
        tick;
        v2 = 0;
        chk("n6_err_pulse", err2, 1);
        tick;
        chk("n6_err_clear", err2, 0);
        v2 = 1; idx2 = 3'd2; reg2 = 1; inv2 = 0; oe2 = 1;
        tick;
        v2 = 0;
        chk("n6_err_valid_idx", err2, 0);
        commit2 = 1;
        tick;
        commit2 = 0;
        begin
            int w;
            w = 0;
            while (!done2 && w < 200) begin tick; w++; end
            chk("n6_done_timeout", (w < 200), 1);
            chk("n6_done_latency", w + 1, 74);
        end
        chk("n6_cfg_reg", cfgr2, 6'h04);
        chk("n6_cfg_inv", cfgi2, 6'h00);
        chk("n6_cfg_oe", cfgo2, 6'h3F);

        // Minimum timing: N_OLMC=1, DIV=1
        commit3 = 1;
        tick;
        commit3 = 0;
        begin
            logic [5:0] sseq;
            int shift_n, dk;
            sseq = '0; shift_n = 0; dk = -1;
            for (int k = 1; k <= 10; k++) begin
                if (k <= 6) sseq = {sseq[4:0], sclk3};
                if (busy3 && !sload3) shift_n++;
                if (done3 && dk < 0) dk = k;
                tick;
            end
            chk("n1_sclk_seq", sseq, 6'b010101);
            chk("n1_shift_len", shift_n, 6);
            chk("n1_done_k", dk, 8);
        end

        // Basic frame: write idx 3 reg=1, commit
        req_valid = 1; req_idx = 3'd3; req_reg = 1; req_inv = 0; req_oe = 1;
        tick;
        req_valid = 0;
        commit = 1;
        tick;
        commit = 0;
        run_mon(100, -1, bits, rises, bf, bl, slk, dk1, dk2, dn, stab, rdy_inj, cmid);
        chk("f1_bits", bits[23:0], 24'h924B24);
        chk("f1_rises", rises, 24);
        chk("f1_busy_first", bf, 1);
        chk("f1_busy_last", bl, 97);
        chk("f1_sload_k", slk, 97);
        chk("f1_done_k", dk1, 98);
        chk("f1_done_n", dn, 1);
        chk("f1_sdo_stable", stab, 0);
        chk("f1_cfg_during_frame", cmid, 8'h00);
        chk("f1_cfg_reg", cfg_reg, 8'h08);

        // Commit and write during SHIFT: merged into one pending frame
        commit = 1;
        tick;
        commit = 0;
        run_mon(200, 10, bits, rises, bf, bl, slk, dk1, dk2, dn, stab, rdy_inj, cmid);
        chk("pend_ready_in_shift", rdy_inj, 0);
        chk("pend_done_n", dn, 2);
        chk("pend_done_k1", dk1, 98);
        chk("pend_done_k2", dk2, 196);
        chk("pend_busy_last", bl, 195);
        chk("pend_rises", rises, 48);
        chk("pend_bits", bits[47:0], 48'h924B24_924B24);
        chk("pend_cfg_reg", cfg_reg, 8'h08);

        // Write idx 0 inv=1 and commit in the same IDLE cycle
        req_valid = 1; req_idx = 3'd0; req_reg = 0; req_inv = 1; req_oe = 1;
        commit = 1;
        tick;
        req_valid = 0;
        commit = 0;
        run_mon(100, -1, bits, rises, bf, bl, slk, dk1, dk2, dn, stab, rdy_inj, cmid);
        chk("same_cyc_last3", bits[2:0], 3'b110);
        chk("same_cyc_bits", bits[23:0], 24'h924B26);
        chk("same_cyc_cfg_inv", cfg_inv, 8'h01);
        chk("same_cyc_cfg_reg", cfg_reg, 8'h08);

        // Reset mid-frame at cycle t+40
        commit = 1;
        tick;
        commit = 0;
        for (int k = 1; k < 40; k++) tick;
        chk("abort_busy_before", busy, 1);
        R = 1;
        tick;
        chk("abort_sclk", sclk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cfg_reg", cfg_reg, 8'h00);
        chk("abort_cfg_inv", cfg_inv, 8'h00);
        chk("abort_cfg_oe", cfg_oe, 8'hFF);
        R = 0;
        begin
            int dcount;
            dcount = 0;
            for (int k = 0; k < 120; k++) begin
                if (done) dcount++;
                tick;
            end
            chk("abort_no_done", dcount, 0);
            chk("abort_idle_ready", req_ready, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
